// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 8-function LogicUnit ALU: accepts a command, drives the ALU for one cycle, returns the registered result.
// Optional build macro ALU_SEQ_STATS_EN adds saturating response/error counters (stat_done, stat_err).
module alu_cmd_sequencer #(
    parameter int N     = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [2:0]       alu_control,
    input  logic [N-1:0]     alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_zero,
    output logic             rsp_err
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]      stat_done,
    output logic [15:0]      stat_err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    // The ALU floats its output for this code, so it is answered without an execute cycle.
    localparam logic [2:0] OP_RSVD = 3'b011;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_q;
    logic       accept;
    logic       rsp_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        alu_control = 3'b000;
        accept      = 1'b0;
        rsp_hs      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid;
                if (cmd_valid) begin
                    state_nxt = (cmd_op == OP_RSVD) ? RESP : EXEC;
                end
            end
            EXEC: begin
                alu_control = op_q;
                state_nxt   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_hs    = rsp_ready;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands stay on alu_a/alu_b after execute so the ALU inputs do not toggle while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            op_q       <= 3'b000;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                op_q    <= cmd_op;
                rsp_tag <= cmd_tag;
                if (cmd_op == OP_RSVD) begin
                    rsp_result <= '0;
                    rsp_zero   <= 1'b1;
                    rsp_err    <= 1'b1;
                end
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= (alu_result == '0);
                rsp_err    <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_done <= 16'd0;
            stat_err  <= 16'd0;
        end else if (rsp_hs) begin
            stat_done <= sat_inc(stat_done);
            if (rsp_err) begin
                stat_err <= sat_inc(stat_err);
            end
        end
    end
`endif

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side initiator for the 8-function LogicUnit ALU.
- Accepts opcode/operand commands over a valid/ready handshake and drives the ALU's A, B and alu_control inputs for one execute cycle.
- Registers the ALU result and returns it, with status flags, over a second valid/ready handshake.
- Sits between an instruction/test source and the combinational ALU; the ALU is instantiated externally.

Parameters:
- N, 8, operand/result width; matches the ALU's N.
- TAG_W, 4, width of the opaque tag carried from command to response.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 011 reserved, 100 A&~B, 101 A|~B, 110 SUB, 111 SLT.
- cmd_a  in  N  operand A.
- cmd_b  in  N  operand B.
- cmd_tag  in  TAG_W  caller tag.
- alu_a  out  N  to ALU A.
- alu_b  out  N  to ALU B.
- alu_control  out  3  to ALU alu_control.
- alu_result  in  N  from ALU result (combinational).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  N  registered result.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_zero  out  1  rsp_result == 0.
- rsp_err  out  1  reserved opcode was issued.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- cmd_ready = 1 only in IDLE. Accept = cmd_valid & cmd_ready at a rising edge.
- On accept, capture op/a/b/tag into internal registers.
  - Legal op: go to EXEC.
  - op == 011: go directly to RESP with rsp_result = 0, rsp_zero = 1, rsp_err = 1. The ALU is never driven with 011, because the ALU outputs Z for that code.
- EXEC lasts exactly one cycle.
  - alu_a, alu_b and alu_control present the captured values.
  - At the closing edge, alu_result is registered into rsp_result, rsp_zero = (alu_result == 0), rsp_err = 0.
  - Next state is RESP.
- RESP: rsp_valid = 1, with result, tag and flags held stable until rsp_valid & rsp_ready at an edge, then return to IDLE. The block accepts no new command while in RESP.
- Latency, accept edge to rsp_valid high:
  - legal op: 2 edges;
  - reserved op: 1 edge.
- Minimum occupancy is 3 cycles per command when rsp_ready is tied high.
- Outside EXEC: alu_control = 000, and alu_a/alu_b hold the last captured operands. They do not toggle while idle.
- Expected ALU arithmetic, which the bench checks end-to-end:
  - ADD and SUB wrap modulo 2^N; no carry or borrow output.
  - SLT is an unsigned compare, zero-extended to N bits.
- Tags are returned unmodified and never interpreted.
- rsp_ready high while rsp_valid is low has no effect.
- cmd_valid may be held high across busy cycles. The command is taken on the first IDLE edge; its fields must stay stable until then.
- Reset (any state, including mid-EXEC or mid-RESP), all at the next edge:
  - state = IDLE;
  - cmd_ready = 1 after the reset edge;
  - rsp_valid = 0, rsp_result = 0, rsp_tag = 0, rsp_zero = 0, rsp_err = 0;
  - alu_a = 0, alu_b = 0, alu_control = 000;
  - any in-flight command is discarded with no response.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- When defined, adds outputs stat_done (16 bits) and stat_err (16 bits).
  - stat_done increments on every response handshake.
  - stat_err increments on every response handshake with rsp_err = 1.
  - Both saturate at 16'hFFFF and clear on rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- After reset, with cmd_valid = 0 → cmd_ready = 1, rsp_valid = 0, alu_control = 000, all response outputs 0.
- ADD a=8'hF0, b=8'h20, tag=3, rsp_ready=1 → rsp_valid two edges after accept, rsp_result = 8'h10, rsp_tag = 3, rsp_zero = 0, rsp_err = 0.
- SUB a=5, b=5 → rsp_result = 0, rsp_zero = 1. Then SLT a=3, b=9 → rsp_result = 1.
- op=011, a=8'hAA, b=8'h55 → rsp_valid one edge after accept, rsp_err = 1, rsp_result = 0, and alu_control never equals 011.
- rsp_ready held 0 for 5 cycles with cmd_valid held 1 → cmd_ready stays 0 and response fields stay stable. When rsp_ready rises, the second command is accepted the cycle after the response handshake.
- rst asserted during EXEC of an AND command → no response is issued, and cmd_ready = 1 the cycle after reset deasserts. With ALU_SEQ_STATS_EN, stat_done = 0.
